alu_rs_scheduler: RTL and testbench
===================================

Name: alu_rs_scheduler

Overview:
- 8-entry reservation station and dispatch scheduler for the single shared combinational ALU.
- Accepts decoded ALU ops from the issue stage, tracks operand tags, and wakes entries from CDB broadcasts.
- Each cycle, selects one ready entry, drives the ALU, registers the result and offers it to the CDB arbiter with a valid/grant handshake.
- Sits between the decoder/ROB and the CDB.

Parameters:
- DEPTH, 8, number of RS entries (power of two, 2..16)
- TAG_W, 4, ROB tag width
- XLEN, 32, operand/result width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; all state frozen when low
- flush  in  1  mispredict flush; clears all entries and the output slot
- issue_valid  in  1  new op offered
- issue_ready  out  1  at least one free entry
- issue_op  in  4  ALU op code (shared encoding in constants.v)
- issue_vj, issue_vk  in  XLEN  operand values when not pending
- issue_qj_busy, issue_qk_busy  in  1  operand pending on a tag
- issue_qj, issue_qk  in  TAG_W  producer tags
- issue_dest  in  TAG_W  destination ROB tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  XLEN  broadcast value
- alu_ready  out  1  ALU enable
- alu_lv, alu_rv  out  XLEN  ALU operands
- alu_op  out  4  ALU op
- alu_result  in  XLEN  ALU result (combinational)
- alu_success  in  1  ALU result valid
- out_valid  out  1  result slot full
- out_tag  out  TAG_W  result tag
- out_value  out  XLEN  result value
- out_grant  in  1  CDB arbiter accepts the slot this cycle

Behaviour:
- Reset values: all entries invalid, issue_ready=1, alu_ready=0, alu_lv/alu_rv=0, alu_op=0, out_valid=0, out_tag=0, out_value=0.
- Reset is checked first at each posedge. flush has the next priority and behaves identically to reset for all state. An op issued in the same cycle as flush is dropped.
- rdy=0: no state changes. alu_ready=0. Grant and CDB inputs are ignored.
- Entry fields: valid, op, vj, vk, jbusy, kbusy, qj, qk, dest.
- issue_ready = any entry invalid. It is computed from current state only; an entry freed in the same cycle is not counted.
- Issue: when issue_valid & issue_ready & rdy, write the lowest-index free entry at the posedge.
- Issue-time bypass: if cdb_valid and cdb_tag matches issue_qj (or issue_qk) with busy set, store cdb_value and clear busy.
- Wakeup: every rdy cycle, each valid entry with jbusy & qj==cdb_tag captures cdb_value into vj and clears jbusy. Same for k.
- Own results wake entries only through the CDB inputs. There is no internal forwarding.
- Ready entry: valid & !jbusy & !kbusy. Select the lowest-index ready entry.
- An entry woken at edge N is ready in cycle N+1.
- Dispatch is allowed when rdy & a ready entry exists & (!out_valid | out_grant).
  - alu_ready=1, and alu_lv/alu_rv/alu_op come combinationally from the selected entry.
- At the posedge of a dispatch cycle with alu_success=1:
  - out_value<=alu_result, out_tag<=dest, out_valid<=1.
  - The selected entry is invalidated.
- If alu_success=0 during dispatch, the entry stays valid and is retried the next cycle.
- Output slot:
  - out_grant with no new dispatch: out_valid<=0.
  - out_grant with a dispatch: the slot is refilled in the same edge.
  - out_valid & !out_grant: out_tag/out_value hold stable and dispatch stalls.
- Latency: an op issued with both operands ready at edge N dispatches in cycle N+1 and has out_valid=1 after edge N+1.
- Throughput: one result per cycle while out_grant is held high.
- Simultaneous issue and free: allowed. The freed entry is reusable from the next cycle.
- Illegal op codes are passed through to the ALU unchanged.

Decomposition:
- constants.v holds:
  - the shared 4-bit ALU op codes (Add, Minus, And, Or, Xor, LeftShift, RightShift, RightShift_A, Less, Equal, NotEqual, GEQ)
  - TAG_W and XLEN defaults
  - True/False
- Sub-module alu_rs_pick: a DEPTH-bit find-first-set priority encoder with found flag and index output. It is instantiated twice: once for the free-entry search and once for the ready-entry search.

Test Plan:
- Reset held 2 cycles → issue_ready=1, out_valid=0, alu_ready=0. Issue with rst=1 → no entry written.
- Issue Add vj=5 vk=7 dest=3, both ready, at edge 0 → cycle 1 alu_ready=1, alu_op=Add; after edge 1 out_valid=1, out_tag=3, out_value=12.
- Issue Minus with qj=2 busy, vk=4 → no dispatch. CDB tag=2 value=10 → next cycle dispatch, out_value=6. Also issue with qj=5 in the same cycle as a CDB tag=5 broadcast → captured at issue, dispatched the next cycle.
- Issue 8 ops all dependent on tag 9 → issue_ready=0 and a 9th issue is ignored. Broadcast tag 9 → entries retire lowest index first, one per cycle, and issue_ready returns to 1 after the first retire.
- out_grant=0 with 2 ready entries → the first result holds out_value stable and alu_ready=0. Grant for one cycle → the second result is loaded on the same edge.
- 3 pending entries with out_valid=1, then flush=1 plus issue_valid=1 in the same cycle → next cycle all entries empty, out_valid=0, new op not written, issue_ready=1.

Source files
------------

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared constants for the ALU reservation station: ALU op codes,
// default tag/data widths and boolean literals.
package alu_rs_scheduler_pkg;

  localparam int TAG_W_DEFAULT = 4;
  localparam int XLEN_DEFAULT  = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [3:0] {
    OP_ADD          = 4'd0,
    OP_MINUS        = 4'd1,
    OP_AND          = 4'd2,
    OP_OR           = 4'd3,
    OP_XOR          = 4'd4,
    OP_LEFT_SHIFT   = 4'd5,
    OP_RIGHT_SHIFT  = 4'd6,
    OP_RIGHT_SHIFT_A = 4'd7,
    OP_LESS         = 4'd8,
    OP_EQUAL        = 4'd9,
    OP_NOT_EQUAL    = 4'd10,
    OP_GEQ          = 4'd11
  } alu_op_e;

endpackage

// File: rtl/alu_rs_pick.sv
// Find-first-set priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module alu_rs_pick #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
    found = 1'b0;
    idx   = '0;
    // Scanning downward lets the lowest set bit be the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// Reservation station and dispatch scheduler for the shared combinational ALU:
// holds ops until their operands arrive on the CDB, then feeds one per cycle.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEFAULT,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_op,
  input  logic [XLEN-1:0]  issue_vj,
  input  logic [XLEN-1:0]  issue_vk,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [TAG_W-1:0] issue_dest,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  output logic             alu_ready,
  output logic [XLEN-1:0]  alu_lv,
  output logic [XLEN-1:0]  alu_rv,
  output logic [3:0]       alu_op,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_success,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_value,
  input  logic             out_grant
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]       op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic             jbusy;
    logic             kbusy;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] dest;
  } entry_t;

  logic [DEPTH-1:0] valid;
  entry_t           rs [DEPTH];

  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] ready_vec;
  logic             free_found;
  logic             ready_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             dispatch;
  logic             fire;
  logic             issue_we;
  entry_t           new_entry;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i]  = !valid[i];
      ready_vec[i] = valid[i] && !rs[i].jbusy && !rs[i].kbusy;
    end
  end

  alu_rs_pick #(.DEPTH(DEPTH)) u_free_pick (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  alu_rs_pick #(.DEPTH(DEPTH)) u_ready_pick (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (sel_idx)
  );

  // A held result that is not being granted blocks dispatch.
  assign issue_ready = free_found;
  assign issue_we    = issue_valid && free_found;
  assign dispatch    = rdy && ready_found && (!out_valid || out_grant);
  assign fire        = dispatch && alu_success;

  always_comb begin
    alu_ready = dispatch;
    alu_lv    = '0;
    alu_rv    = '0;
    alu_op    = '0;
    if (dispatch) begin
      alu_lv = rs[sel_idx].vj;
      alu_rv = rs[sel_idx].vk;
      alu_op = rs[sel_idx].op;
    end
  end

  // Operands broadcast in the issue cycle are captured directly.
  always_comb begin
    new_entry.op    = issue_op;
    new_entry.vj    = issue_vj;
    new_entry.vk    = issue_vk;
    new_entry.jbusy = issue_qj_busy;
    new_entry.kbusy = issue_qk_busy;
    new_entry.qj    = issue_qj;
    new_entry.qk    = issue_qk;
    new_entry.dest  = issue_dest;
    if (cdb_valid && issue_qj_busy && issue_qj == cdb_tag) begin
      new_entry.vj    = cdb_value;
      new_entry.jbusy = FALSE;
    end
    if (cdb_valid && issue_qk_busy && issue_qk == cdb_tag) begin
      new_entry.vk    = cdb_value;
      new_entry.kbusy = FALSE;
    end
  end

  // NOTE: payload storage has no reset; the valid bits alone decide whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (!rst && !flush && rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_we && free_idx == IDX_W'(i)) begin
          rs[i] <= new_entry;
        end else begin
          if (valid[i] && rs[i].jbusy && cdb_valid && rs[i].qj == cdb_tag) begin
            rs[i].vj    <= cdb_value;
            rs[i].jbusy <= FALSE;
          end
          if (valid[i] && rs[i].kbusy && cdb_valid && rs[i].qk == cdb_tag) begin
            rs[i].vk    <= cdb_value;
            rs[i].kbusy <= FALSE;
          end
        end
      end
    end
  end

  // NOTE: non-blocking assignments keep every read in this block on pre-edge state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid     <= '0;
      out_valid <= FALSE;
      out_tag   <= '0;
      out_value <= '0;
    end else if (rdy) begin
      // The issue slot is always a free entry, so it never collides with the retiring one.
      if (fire)     valid[sel_idx]  <= FALSE;
      if (issue_we) valid[free_idx] <= TRUE;
      if (fire) begin
        out_valid <= TRUE;
        out_tag   <= rs[sel_idx].dest;
        out_value <= alu_result;
      end else if (out_grant) begin
        out_valid <= FALSE;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler: directed scenarios followed by random
// traffic, checked against a behavioural reservation-station model.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst, rdy, flush;
  logic             issue_valid, issue_ready;
  logic [3:0]       issue_op;
  logic [XLEN-1:0]  issue_vj, issue_vk;
  logic             issue_qj_busy, issue_qk_busy;
  logic [TAG_W-1:0] issue_qj, issue_qk, issue_dest;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             alu_ready;
  logic [XLEN-1:0]  alu_lv, alu_rv, alu_result;
  logic [3:0]       alu_op;
  logic             alu_success;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_value;
  logic             out_grant;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_rs_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_dest(issue_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_ready(alu_ready), .alu_lv(alu_lv), .alu_rv(alu_rv), .alu_op(alu_op),
    .alu_result(alu_result), .alu_success(alu_success),
    .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value),
    .out_grant(out_grant)
  );

  // Behavioural ALU; undefined op codes produce a deterministic scramble.
  function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_ADD:           return a + b;
      OP_MINUS:         return a - b;
      OP_AND:           return a & b;
      OP_OR:            return a | b;
      OP_XOR:           return a ^ b;
      OP_LEFT_SHIFT:    return a << b[4:0];
      OP_RIGHT_SHIFT:   return a >> b[4:0];
      OP_RIGHT_SHIFT_A: return 32'($signed(a) >>> b[4:0]);
      OP_LESS:          return {31'd0, $signed(a) < $signed(b)};
      OP_EQUAL:         return {31'd0, a == b};
      OP_NOT_EQUAL:     return {31'd0, a != b};
      OP_GEQ:           return {31'd0, $signed(a) >= $signed(b)};
      default:          return a ^ b ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_op, alu_lv, alu_rv);

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          valid;
    logic [3:0]  op;
    logic [31:0] a, b;
    bit          a_wait, b_wait;
    logic [3:0]  a_tag, b_tag, dest;
  } m_op_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
  } res_t;

  m_op_t m_rs [DEPTH];
  bit    m_slot_full = 0;
  res_t  m_slot;
  res_t  exp_q [$];

  function automatic bit m_empty();
    foreach (m_rs[i]) if (m_rs[i].valid) return 0;
    return !m_slot_full;
  endfunction

  task automatic model_step();
    int   free_i = -1;
    int   sel_i  = -1;
    bit   go;
    m_op_t n;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_i < 0 && !m_rs[i].valid) free_i = i;
      if (sel_i < 0 && m_rs[i].valid && !m_rs[i].a_wait && !m_rs[i].b_wait) sel_i = i;
    end
    go = rdy && sel_i >= 0 && (!m_slot_full || out_grant);

    check("issue_ready", issue_ready, free_i >= 0);
    check("alu_ready", alu_ready, go);
    check("out_valid", out_valid, m_slot_full);
    if (go) begin
      check("alu_op", alu_op, m_rs[sel_i].op);
      check("alu_lv", alu_lv, m_rs[sel_i].a);
      check("alu_rv", alu_rv, m_rs[sel_i].b);
    end

    if (rst || flush) begin
      foreach (m_rs[i]) m_rs[i].valid = 0;
      m_slot_full = 0;
    end else if (rdy) begin
      if (m_slot_full && out_grant) exp_q.push_back(m_slot);
      if (go && alu_success) begin
        m_slot.tag  = m_rs[sel_i].dest;
        m_slot.val  = alu_ref(m_rs[sel_i].op, m_rs[sel_i].a, m_rs[sel_i].b);
        m_slot_full = 1;
        m_rs[sel_i].valid = 0;
      end else if (out_grant) begin
        m_slot_full = 0;
      end
      if (cdb_valid) begin
        foreach (m_rs[i]) begin
          if (m_rs[i].valid && m_rs[i].a_wait && m_rs[i].a_tag == cdb_tag) begin
            m_rs[i].a = cdb_value; m_rs[i].a_wait = 0;
          end
          if (m_rs[i].valid && m_rs[i].b_wait && m_rs[i].b_tag == cdb_tag) begin
            m_rs[i].b = cdb_value; m_rs[i].b_wait = 0;
          end
        end
      end
      if (issue_valid && free_i >= 0) begin
        n.valid  = 1;
        n.op     = issue_op;
        n.dest   = issue_dest;
        n.a_tag  = issue_qj;
        n.b_tag  = issue_qk;
        n.a_wait = issue_qj_busy && !(cdb_valid && cdb_tag == issue_qj);
        n.b_wait = issue_qk_busy && !(cdb_valid && cdb_tag == issue_qk);
        n.a      = (issue_qj_busy && !n.a_wait) ? cdb_value : issue_vj;
        n.b      = (issue_qk_busy && !n.b_wait) ? cdb_value : issue_vk;
        m_rs[free_i] = n;
      end
    end
  endtask

  initial begin : model_proc
    foreach (m_rs[i]) m_rs[i].valid = 0;
    forever begin
      @(negedge clk);
      #3;
      model_step();
    end
  end

  // Monitor: pops one expectation per accepted result.
  initial begin : monitor_proc
    res_t r;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && !flush && rdy && out_valid && out_grant) begin
        check("sb_result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          check("sb_out_tag", out_tag, r.tag);
          check("sb_out_value", out_value, r.val);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_idle();
    issue_valid = 0; issue_op = '0; issue_vj = '0; issue_vk = '0;
    issue_qj_busy = 0; issue_qk_busy = 0; issue_qj = '0; issue_qk = '0; issue_dest = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
    out_grant = 1; alu_success = 1; rdy = 1; flush = 0;
  endtask

  task automatic issue(logic [3:0] op, logic [31:0] vj, logic [31:0] vk, bit jb, logic [3:0] qj,
                       bit kb, logic [3:0] qk, logic [3:0] dest);
    drive_idle();
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = jb; issue_qj = qj; issue_qk_busy = kb; issue_qk = qk; issue_dest = dest;
  endtask

  task automatic broadcast(logic [3:0] tag, logic [31:0] val);
    cdb_valid = 1; cdb_tag = tag; cdb_value = val;
  endtask

  initial begin : main_proc
    rst = 1;
    drive_idle();
    @(negedge clk);
    issue(OP_ADD, 1, 1, 0, 0, 0, 0, 1);          // offered during reset, must be dropped
    @(negedge clk); rst = 0; drive_idle(); #2;
    check("reset_issue_ready", issue_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_alu_ready", alu_ready, 0);

    // Back-to-back latency with both operands ready
    @(negedge clk); issue(OP_ADD, 5, 7, 0, 0, 0, 0, 3);
    @(negedge clk); drive_idle(); #2;
    check("lat_alu_ready", alu_ready, 1);
    check("lat_alu_op", alu_op, OP_ADD);
    @(negedge clk); drive_idle(); #2;
    check("lat_out_valid", out_valid, 1);
    check("lat_out_tag", out_tag, 3);
    check("lat_out_value", out_value, 12);

    // CDB wakeup, then issue-time bypass
    @(negedge clk); issue(OP_MINUS, 0, 4, 1, 2, 0, 0, 4);
    @(negedge clk); drive_idle(); broadcast(2, 10); #2;
    check("wait_alu_ready", alu_ready, 0);
    @(negedge clk); drive_idle(); #2;
    check("wake_alu_ready", alu_ready, 1);
    check("wake_alu_lv", alu_lv, 10);
    @(negedge clk); issue(OP_ADD, 0, 1, 1, 5, 0, 0, 5); broadcast(5, 20); #2;
    check("wake_out_value", out_value, 6);
    @(negedge clk); drive_idle(); #2;
    check("bypass_alu_ready", alu_ready, 1);
    check("bypass_alu_lv", alu_lv, 20);
    @(negedge clk); drive_idle(); #2;
    check("bypass_out_tag", out_tag, 5);
    check("bypass_out_value", out_value, 21);

    // Fill all entries on tag 9, reject a ninth, then drain in index order
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); issue(OP_ADD, 0, 32'(i), 1, 9, 0, 0, 4'(i));
    end
    @(negedge clk); issue(OP_ADD, 1, 1, 0, 0, 0, 0, 15); #2;
    check("full_issue_ready", issue_ready, 0);
    @(negedge clk); drive_idle(); broadcast(9, 100); #2;
    check("full_alu_ready", alu_ready, 0);
    @(negedge clk); drive_idle(); #2;
    check("drain0_alu_rv", alu_rv, 0);
    check("drain0_issue_ready", issue_ready, 0);
    @(negedge clk); drive_idle(); #2;
    check("drain_issue_ready", issue_ready, 1);
    check("drain_out_tag", out_tag, 0);
    check("drain_out_value", out_value, 100);
    repeat (9) @(negedge clk);

    // Output back-pressure and same-edge refill
    issue(OP_ADD, 1, 1, 0, 0, 0, 0, 1); out_grant = 0;
    @(negedge clk); issue(OP_ADD, 2, 2, 0, 0, 0, 0, 2); out_grant = 0;
    @(negedge clk); drive_idle(); out_grant = 0; #2;
    check("hold_alu_ready", alu_ready, 0);
    check("hold_out_value", out_value, 2);
    @(negedge clk); drive_idle(); out_grant = 0; #2;
    check("hold2_out_tag", out_tag, 1);
    check("hold2_out_value", out_value, 2);
    @(negedge clk); drive_idle(); #2;
    check("refill_alu_ready", alu_ready, 1);
    @(negedge clk); drive_idle(); out_grant = 0; #2;
    check("refill_out_valid", out_valid, 1);
    check("refill_out_tag", out_tag, 2);
    check("refill_out_value", out_value, 4);

    // Flush with pending entries, a full slot and a simultaneous issue
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); issue(OP_XOR, 0, 32'(i), 1, 12, 0, 0, 4'(6 + i)); out_grant = 0;
    end
    @(negedge clk); issue(OP_ADD, 3, 3, 0, 0, 0, 0, 9); flush = 1; out_grant = 0;
    @(negedge clk); drive_idle(); broadcast(12, 1); #2;
    check("flush_issue_ready", issue_ready, 1);
    check("flush_out_valid", out_valid, 0);
    check("flush_alu_ready", alu_ready, 0);
    @(negedge clk); drive_idle(); #2;
    check("flush_empty_alu_ready", alu_ready, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst           = ($urandom % 600) == 0;
      rdy           = ($urandom % 10) != 0;
      flush         = ($urandom % 50) == 0;
      issue_valid   = $urandom % 2;
      issue_op      = 4'($urandom % 16);
      issue_vj      = $urandom;
      issue_vk      = ($urandom % 2) ? $urandom : 32'($urandom % 40);
      issue_qj_busy = ($urandom % 5) < 2;
      issue_qk_busy = ($urandom % 5) < 2;
      issue_qj      = 4'($urandom % 16);
      issue_qk      = 4'($urandom % 16);
      issue_dest    = 4'($urandom % 16);
      cdb_valid     = $urandom % 2;
      cdb_tag       = 4'($urandom % 16);
      cdb_value     = $urandom;
      out_grant     = ($urandom % 4) != 0;
      alu_success   = ($urandom % 8) != 0;
    end

    // Drain: wake every tag, grant everything
    for (int c = 0; c < 48; c++) begin
      @(negedge clk); drive_idle(); broadcast(4'(c % 16), $urandom);
    end
    @(negedge clk); drive_idle(); #5;
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_model_empty", m_empty(), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
